// File: rtl/decode_issue_ctrl_if.sv
// Fetch/issue/writeback bundle between the fetch stage, decode_issue_ctrl and execute.
// The master side drives fetch words, execute ready, flush and writeback; the slave side is decode.
interface decode_issue_ctrl_if;
    logic        if_valid;
    logic [15:0] instruction;
    logic        if_ready;
    logic        id_valid;
    logic        ex_ready;
    logic        flush;
    logic [2:0]  id_reg1;
    logic [2:0]  id_reg2;
    logic [7:0]  id_imm;
    logic [2:0]  id_dest;
    logic        id_fmt;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [7:0]  stall_cycles;
    logic [7:0]  pending;

    modport master (
        output if_valid, instruction, ex_ready, flush, wb_valid, wb_reg,
        input  if_ready, id_valid, id_reg1, id_reg2, id_imm, id_dest, id_fmt,
               stall_cycles, pending
    );

    modport slave (
        input  if_valid, instruction, ex_ready, flush, wb_valid, wb_reg,
        output if_ready, id_valid, id_reg1, id_reg2, id_imm, id_dest, id_fmt,
               stall_cycles, pending
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode/issue stage: decodes 16-bit words, blocks RAW/WAW hazards on a pending scoreboard.
// Optional macro DECODE_WB_BYPASS_EN lets a same-cycle writeback release a hazard.
module decode_issue_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_issue_ctrl_if.slave   bus
);
    localparam int unsigned REG_W  = 3;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic [REG_W-1:0]   r_reg1;
    logic [REG_W-1:0]   r_reg2;
    logic [REG_W-1:0]   r_dest;
    logic [IMM_W-1:0]   r_imm;
    logic               r_fmt;
    logic [NREGS-1:0]   r_pending;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_fmt;
    logic [REG_W-1:0]   w_reg1;
    logic [REG_W-1:0]   w_reg2;
    logic [REG_W-1:0]   w_dest;
    logic [IMM_W-1:0]   w_imm;
    logic [NREGS-1:0]   w_srcs;
    logic               w_xfer;
    logic [NREGS-1:0]   w_set_mask;
    logic [NREGS-1:0]   w_clr_mask;
    logic [NREGS-1:0]   w_busy;
    logic [NREGS-1:0]   w_pending_nxt;
    logic               w_hazard;
    logic               w_slot_free;
    logic               w_capture;
    logic               w_blocked;
    logic               w_stall_inc;
    logic               w_unused_bits;

    // Field extraction for the R and I formats
    always_comb begin
        w_fmt  = bus.instruction[15];
        w_reg1 = bus.instruction[5:3];
        w_reg2 = bus.instruction[2:0];
        w_imm  = {5'b0, bus.instruction[2:0]};
        w_dest = bus.instruction[8:6];
        w_srcs = (NREGS'(1) << w_reg1) | (NREGS'(1) << w_reg2);
        if (w_fmt) begin
            w_reg1 = bus.instruction[10:8];
            w_reg2 = '0;
            w_imm  = bus.instruction[7:0];
            w_dest = bus.instruction[10:8];
            w_srcs = '0;
        end
    end

    assign w_unused_bits = ^bus.instruction[14:11];

    // The outgoing bundle's dest counts as pending for the word decoded alongside it
    assign w_xfer        = r_valid & bus.ex_ready & ~bus.flush;
    assign w_set_mask    = w_xfer ? (NREGS'(1) << r_dest) : '0;
    assign w_clr_mask    = bus.wb_valid ? (NREGS'(1) << bus.wb_reg) : '0;
    assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
`ifdef DECODE_WB_BYPASS_EN
    assign w_busy        = w_pending_nxt;
`else
    assign w_busy        = r_pending | w_set_mask;
`endif
    assign w_hazard      = |(w_busy & (w_srcs | (NREGS'(1) << w_dest)));
    assign w_slot_free   = ~r_valid | bus.ex_ready;
    assign w_capture     = bus.if_valid & ~bus.flush & ~w_hazard & w_slot_free;
    assign w_blocked     = bus.if_valid & ~bus.flush & w_hazard;

    // Next-state: STALL holds only while a presented word stays blocked
    always_comb begin
        w_state_nxt = r_state;
        w_stall_inc = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_blocked) w_state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (w_blocked) w_stall_inc = 1'b1;
                else           w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_valid     <= 1'b0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_dest      <= '0;
            r_imm       <= '0;
            r_fmt       <= 1'b0;
            r_pending   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (bus.flush)     r_valid <= 1'b0;
            else if (w_capture) r_valid <= 1'b1;
            else if (w_xfer)   r_valid <= 1'b0;
            if (w_capture) begin
                r_reg1 <= w_reg1;
                r_reg2 <= w_reg2;
                r_dest <= w_dest;
                r_imm  <= w_imm;
                r_fmt  <= w_fmt;
            end
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.if_ready     = w_capture;
    assign bus.id_valid     = r_valid;
    assign bus.id_reg1      = r_reg1;
    assign bus.id_reg2      = r_reg2;
    assign bus.id_dest      = r_dest;
    assign bus.id_imm       = r_imm;
    assign bus.id_fmt       = r_fmt;
    assign bus.pending      = r_pending;
    assign bus.stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus random traffic against a scoreboard model.
module tb_decode_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_issue_ctrl_if bus();
    decode_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_pend [8];
    bit m_valid;
    int m_r1, m_r2, m_imm, m_dest, m_fmt;
    int m_stall;
    bit m_stalled;
    bit m_ready;
    bit m_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pend_word();
        int w = 0;
        for (int r = 0; r < 8; r++) if (m_pend[r]) w += (1 << r);
        return w;
    endfunction

    function automatic bit busy(input int r);
        bit wb_hit = bus.wb_valid && (int'(bus.wb_reg) == r);
        return (m_pend[r] && !(BYPASS && wb_hit)) || (m_xfer && m_dest == r);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_pend[r] = 1'b0;
        m_valid = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_dest = 0; m_fmt = 0;
        m_stall = 0; m_stalled = 0; m_ready = 0; m_xfer = 0;
    endtask

    // One clock: compare at negedge, advance model, return at posedge+1
    task automatic step();
        int w, d_r1, d_r2, d_imm, d_dest, d_fmt;
        bit hz, blocked;
        bit np [8];
        @(negedge clk);
        w = int'(bus.instruction);
        d_fmt = (w >> 15) & 1;
        if (d_fmt == 1) begin
            d_r1 = (w >> 8) & 7; d_r2 = 0; d_imm = w & 255; d_dest = d_r1;
        end else begin
            d_r1 = (w >> 3) & 7; d_r2 = w & 7; d_imm = w & 7; d_dest = (w >> 6) & 7;
        end
        m_xfer  = m_valid && bus.ex_ready && !bus.flush;
        hz      = busy(d_dest) || (d_fmt == 0 && (busy(d_r1) || busy(d_r2)));
        m_ready = bus.if_valid && !bus.flush && !hz && (!m_valid || bus.ex_ready);
        blocked = bus.if_valid && !bus.flush && hz;

        check("if_ready", 32'(bus.if_ready), 32'(m_ready));
        check("id_valid", 32'(bus.id_valid), 32'(m_valid));
        check("id_reg1", 32'(bus.id_reg1), m_r1);
        check("id_reg2", 32'(bus.id_reg2), m_r2);
        check("id_imm", 32'(bus.id_imm), m_imm);
        check("id_dest", 32'(bus.id_dest), m_dest);
        check("id_fmt", 32'(bus.id_fmt), m_fmt);
        check("pending", 32'(bus.pending), pend_word());
        check("stall_cycles", 32'(bus.stall_cycles), m_stall);

        for (int r = 0; r < 8; r++)
            np[r] = (m_pend[r] && !(bus.wb_valid && int'(bus.wb_reg) == r)) || (m_xfer && m_dest == r);
        for (int r = 0; r < 8; r++) m_pend[r] = np[r];
        if (m_stalled && blocked) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
        m_stalled = blocked;
        if (bus.flush)       m_valid = 0;
        else if (m_ready)    m_valid = 1;
        else if (m_xfer)     m_valid = 0;
        if (m_ready) begin
            m_r1 = d_r1; m_r2 = d_r2; m_imm = d_imm; m_dest = d_dest; m_fmt = d_fmt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] w, input bit exr, input bit fl,
                         input bit wbv, input logic [2:0] wbr);
        bus.if_valid = v; bus.instruction = w; bus.ex_ready = exr;
        bus.flush = fl; bus.wb_valid = wbv; bus.wb_reg = wbr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_id_valid"}, 32'(bus.id_valid), 0);
        check({tag, "_fields"}, 32'({bus.id_reg1, bus.id_reg2, bus.id_dest, bus.id_imm, bus.id_fmt}), 0);
        check({tag, "_pending"}, 32'(bus.pending), 0);
        check({tag, "_stall"}, 32'(bus.stall_cycles), 0);
    endtask

    // Assert reset asynchronously, hold across one edge, release at posedge+1
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        drive(0, 16'h0, 0, 0, 0, 3'd0);
        do_reset("reset0");

        // R-format issue and scoreboard set on transfer
        drive(1, 16'h0053, 1, 0, 0, 3'd0);
        #1 check("r_fmt_if_ready", 32'(bus.if_ready), 1);
        step();
        check("r_fmt_valid", 32'(bus.id_valid), 1);
        check("r_fmt_reg1", 32'(bus.id_reg1), 2);
        check("r_fmt_reg2", 32'(bus.id_reg2), 3);
        check("r_fmt_imm", 32'(bus.id_imm), 32'h03);
        check("r_fmt_dest", 32'(bus.id_dest), 1);
        drive(0, 16'h0, 1, 0, 0, 3'd0);
        step();
        check("r_fmt_pending", 32'(bus.pending), 32'h02);

        // RAW against the outgoing bundle, stall, writeback release
        drive(0, 16'h0, 0, 0, 0, 3'd0);
        do_reset("reset1");
        drive(1, 16'h8A7F, 1, 0, 0, 3'd0);
        step();
        check("i_fmt_imm", 32'(bus.id_imm), 32'h7F);
        check("i_fmt_fmt", 32'(bus.id_fmt), 1);
        drive(1, 16'h0010, 1, 0, 0, 3'd0);
        #1 check("raw_outgoing_ready", 32'(bus.if_ready), 0);
        step(); step(); step(); step();
        check("stall_count3", 32'(bus.stall_cycles), 3);
        drive(1, 16'h0010, 1, 0, 1, 3'd2);
        #1 check("wb_cycle_ready", 32'(bus.if_ready), 32'(BYPASS));
        step();
        check("wb_cycle_valid", 32'(bus.id_valid), 32'(BYPASS));
        check("wb_pending_clear", 32'(bus.pending), 0);
        drive(1, 16'h0010, 1, 0, 0, 3'd0);
        if (!BYPASS) step();
        check("post_wb_valid", 32'(bus.id_valid), 1);
        check("post_wb_reg1", 32'(bus.id_reg1), 2);
        check("post_wb_stall", 32'(bus.stall_cycles), BYPASS ? 3 : 4);
        drive(0, 16'h0, 1, 0, 0, 3'd0);
        step();

        // Backpressure holds the bundle; pending set exactly once on release
        drive(0, 16'h0, 0, 0, 0, 3'd0);
        do_reset("reset2");
        drive(1, 16'h0053, 0, 0, 0, 3'd0);
        step();
        drive(1, 16'h0088, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_if_ready", 32'(bus.if_ready), 0);
            step();
            check("bp_bundle", 32'({bus.id_valid, bus.id_reg1, bus.id_reg2, bus.id_dest}), 32'({1'b1, 3'd2, 3'd3, 3'd1}));
            check("bp_pending", 32'(bus.pending), 0);
        end
        drive(0, 16'h0, 1, 0, 0, 3'd0);
        step();
        check("bp_release_pending", 32'(bus.pending), 32'h02);
        step();
        check("bp_once_pending", 32'(bus.pending), 32'h02);

        // Flush beats a simultaneous transfer
        drive(0, 16'h0, 0, 0, 0, 3'd0);
        do_reset("reset3");
        drive(1, 16'h0053, 1, 0, 0, 3'd0);
        step();
        drive(1, 16'h0088, 1, 1, 0, 3'd0);
        #1 check("flush_if_ready", 32'(bus.if_ready), 0);
        step();
        check("flush_valid", 32'(bus.id_valid), 0);
        check("flush_pending", 32'(bus.pending), 0);

        // Random traffic; fetch holds its word until accepted
        drive(0, 16'h0, 0, 0, 0, 3'd0);
        do_reset("reset4");
        acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] w;
            bit hold;
            hold = bus.if_valid && !acc;
            w = hold ? bus.instruction : 16'($urandom);
            drive(hold ? 1'b1 : ($urandom_range(0, 99) < 60), w,
                  $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 35, 3'($urandom_range(0, 7)));
            step();
            acc = m_ready;
        end

        // Long stall saturates, then asynchronous reset mid-stall
        drive(0, 16'h0, 0, 0, 0, 3'd0);
        do_reset("reset5");
        drive(1, 16'h8A7F, 1, 0, 0, 3'd0);
        step();
        drive(1, 16'h0010, 1, 0, 0, 3'd0);
        for (int i = 0; i < 301; i++) step();
        check("stall_saturate", 32'(bus.stall_cycles), 255);
        #2;
        do_reset("reset_mid_stall");
        drive(1, 16'h0010, 1, 0, 0, 3'd0);
        step();
        check("post_reset_capture", 32'(bus.id_valid), 1);
        check("post_reset_reg1", 32'(bus.id_reg1), 2);
        drive(0, 16'h0, 1, 0, 0, 3'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 SHALL have no parameters; widths fixed: instruction 16, register index 3, immediate 8.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: if_valid  in  1  fetch instruction valid; instruction  in  16  fetched word; if_ready  out  1  decode accepts fetch word.
REQ-005 SHALL have ports: id_valid  out  1  decoded bundle valid; ex_ready  in  1  execute accepts bundle; flush  in  1  kill bundle not yet accepted.
REQ-006 SHALL have ports: id_reg1  out  3; id_reg2  out  3; id_imm  out  8; id_dest  out  3; id_fmt  out  1  (0 = R, 1 = I).
REQ-007 SHALL have ports: wb_valid  in  1; wb_reg  in  3  writeback retiring a destination.
REQ-008 SHALL have ports: stall_cycles  out  8  saturating hazard-stall count; pending  out  8  scoreboard bits.

Function
REQ-009 Decode SHALL be: bit15=0 -> reg1=[5:3], reg2=[2:0], imm={5'b0,[2:0]}, dest=[8:6], sources reg1 and reg2; bit15=1 -> reg1=[10:8], reg2=0, imm=[7:0], dest=[10:8], no sources.
REQ-010 Hazard SHALL be: any source or dest index has its pending bit set (RAW and WAW).
REQ-011 FSM states SHALL be RUN and STALL.
REQ-012 RUN: if_valid, no hazard, and output slot free or draining (!id_valid or ex_ready) -> capture decode into output registers next edge, id_valid=1, stay RUN.
REQ-013 RUN: if_valid and hazard -> go STALL, no capture.
REQ-014 STALL: hazard still present -> stay STALL, increment stall_cycles (saturate at 255); hazard gone and slot free -> capture, go RUN.
REQ-015 if_ready SHALL be combinational: 1 only when capture conditions of REQ-012/REQ-014 hold in the current cycle.
REQ-016 Output bundle SHALL hold stable while id_valid=1 and ex_ready=0.
REQ-017 Transfer (id_valid and ex_ready) SHALL set pending[id_dest] next edge.
REQ-018 wb_valid SHALL clear pending[wb_reg] next edge; same-index set and clear in one cycle -> set wins.
REQ-019 Transfer and capture in the same cycle SHALL be allowed (back-to-back issue, one per cycle); the new word's hazard check SHALL see the outgoing bundle's dest as pending.
REQ-020 flush SHALL clear id_valid next edge, force state RUN, deassert if_ready that cycle; pending unaffected (killed bundle never set a bit); flush overrides a simultaneous transfer.
REQ-021 Latency fetch-to-id_valid SHALL be one cycle with no hazard.

Reset
REQ-022 rst_n low SHALL immediately force: state RUN, id_valid 0, id_reg1/id_reg2/id_dest 0, id_imm 0, id_fmt 0, pending 0, stall_cycles 0.
REQ-023 Reset asserted mid-stall or mid-transfer SHALL discard all in-flight state; first capture possible on the first edge after release.

Configuration
REQ-024 Macro DECODE_WB_BYPASS_EN defined: a hazard whose only pending register equals wb_reg with wb_valid=1 in the same cycle SHALL NOT count as hazard (writeback bypass).
REQ-025 Macro undefined: such a hazard SHALL stall until the pending bit is clear (one extra cycle).

Verification
REQ-026 Reset, send 0x0053 (R: reg1=2, reg2=3, dest=1), ex_ready=1 -> id_valid next cycle, id_reg1=2, id_reg2=3, id_imm=0x03, id_dest=1, pending=0x02 after transfer.
REQ-027 Send 0x8A7F (I: dest=2, imm=0x7F) then 0x0010 (reads r2) -> second word stalls, stall_cycles increments until wb_valid, wb_reg=2; issues one cycle after clear (no bypass) or same-cycle capture (bypass build).
REQ-028 Hold ex_ready=0 for 3 cycles with id_valid=1 -> bundle unchanged, if_ready=0, pending unchanged; release -> pending set once.
REQ-029 Assert flush with id_valid=1, ex_ready=1 -> id_valid=0 next cycle, pending bit for that dest not set.
REQ-030 Force 300 stall cycles -> stall_cycles stops at 255; drive rst_n low mid-stall -> all outputs 0 asynchronously, state RUN.
